// File: rtl/bvh_traversal_unit.sv
// BVH traversal for a single ray: walks the node tree with a small explicit
// stack, slab-tests each node box and emits leaf primitive ranges.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for strobe
// FETCH  | pop top of stack, present it on node_index
// TEST   | node data valid; slab test, emit leaves, push inner children
// DONE   | traversal complete, finished held high

// Component-wise add of two packed 3-vectors; wraps at FW bits.
module fixed3_add #(
  parameter int FW = 32
) (
  input  logic [3*FW-1:0] a,
  input  logic [3*FW-1:0] b,
  output logic [3*FW-1:0] y
);
  // Per-component wrapping sum
  always_comb begin
    y = '0;
    for (int i = 0; i < 3; i++) y[i*FW +: FW] = a[i*FW +: FW] + b[i*FW +: FW];
  end
endmodule

// Scalar times packed 3-vector in signed Q(FW-16).16; truncated, no saturation.
module fixed3_mul #(
  parameter int FW = 32
) (
  input  logic [FW-1:0]   s,
  input  logic [3*FW-1:0] v,
  output logic [3*FW-1:0] y
);
  logic signed [2*FW-1:0] prod [3];

  // Full-width products, then keep bits [FW+15:16]
  always_comb begin
    y = '0;
    for (int i = 0; i < 3; i++) begin
      prod[i] = $signed(s) * $signed(v[i*FW +: FW]);
      y[i*FW +: FW] = FW'(prod[i] >>> 16);
    end
  end
endmodule

module bvh_traversal_unit #(
  parameter int FW          = 32,
  parameter int NODE_IW     = 8,
  parameter int PRIM_IW     = 8,
  parameter int PRIM_AW     = 4,
  parameter int STACK_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 strobe,
  input  logic                 restart_strobe,
  input  logic [3*FW-1:0]      offset,
  input  logic [3*FW-1:0]      ray_orig,
  input  logic [3*FW-1:0]      ray_invdir,
  input  logic [FW-1:0]        ray_mint,
  input  logic [FW-1:0]        ray_maxt,
  output logic [NODE_IW-1:0]   node_index,
  input  logic [3*FW-1:0]      node_min,
  input  logic [3*FW-1:0]      node_max,
  input  logic [2*NODE_IW-1:0] node_child,
  input  logic [1:0]           node_isleaf,
  input  logic [2*PRIM_IW-1:0] leaf_start,
  input  logic [2*PRIM_AW-1:0] leaf_num,
  output logic [2*PRIM_IW-1:0] start_prim,
  output logic [2*PRIM_AW-1:0] num_prim,
  output logic                 valid,
  output logic                 finished
);
  localparam int SAW = $clog2(STACK_DEPTH);
  localparam int SPW = SAW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_TEST  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [SPW-1:0]       sp_q, sp_d;
  logic [NODE_IW-1:0]   stack_q [STACK_DEPTH];
  logic [NODE_IW-1:0]   stack_d [STACK_DEPTH];
  logic [NODE_IW-1:0]   node_index_q, node_index_d;
  logic [2*PRIM_IW-1:0] start_prim_q, start_prim_d;
  logic [2*PRIM_AW-1:0] num_prim_q, num_prim_d;
  logic                 valid_q, valid_d;
  logic                 finished_q, finished_d;

  logic [3*FW-1:0] neg_orig, box_lo, box_hi, d_lo, d_hi;
  logic signed [FW-1:0] t_a [3];
  logic signed [FW-1:0] t_b [3];
  logic signed [FW-1:0] t_near, t_far;
  logic                 slab_hit, any_leaf;
  logic [SAW-1:0]       top_idx;

  function automatic logic signed [FW-1:0] fx_mul(input logic signed [FW-1:0] a,
                                                  input logic signed [FW-1:0] b);
    logic signed [2*FW-1:0] p;
    p = a * b;
    return FW'(p >>> 16);
  endfunction

  // Subtracting the origin is done as an add of its negation
  always_comb begin
    neg_orig = '0;
    for (int i = 0; i < 3; i++) neg_orig[i*FW +: FW] = -ray_orig[i*FW +: FW];
  end

  fixed3_add #(.FW(FW)) u_lo  (.a(node_min), .b(offset),   .y(box_lo));
  fixed3_add #(.FW(FW)) u_hi  (.a(node_max), .b(offset),   .y(box_hi));
  fixed3_add #(.FW(FW)) u_dlo (.a(box_lo),   .b(neg_orig), .y(d_lo));
  fixed3_add #(.FW(FW)) u_dhi (.a(box_hi),   .b(neg_orig), .y(d_hi));

  // Per-axis slab entry/exit distances
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      t_a[i] = fx_mul(d_lo[i*FW +: FW], ray_invdir[i*FW +: FW]);
      t_b[i] = fx_mul(d_hi[i*FW +: FW], ray_invdir[i*FW +: FW]);
    end
  end

  // Reduce axes to a single interval; a negative maxt leaves the far end open
  always_comb begin
    t_near = $signed(ray_mint);
    t_far  = (t_a[0] > t_b[0]) ? t_a[0] : t_b[0];
    for (int i = 0; i < 3; i++) begin
      if (((t_a[i] < t_b[i]) ? t_a[i] : t_b[i]) > t_near)
        t_near = (t_a[i] < t_b[i]) ? t_a[i] : t_b[i];
      if (((t_a[i] > t_b[i]) ? t_a[i] : t_b[i]) < t_far)
        t_far = (t_a[i] > t_b[i]) ? t_a[i] : t_b[i];
    end
    if (!ray_maxt[FW-1] && ($signed(ray_maxt) < t_far)) t_far = $signed(ray_maxt);
    slab_hit = (t_near <= t_far) && !t_far[FW-1];
  end

  // A group is only worth a valid pulse if some leaf child has primitives
  always_comb begin
    any_leaf = 1'b0;
    for (int k = 0; k < 2; k++)
      if (node_isleaf[k] && (leaf_num[k*PRIM_AW +: PRIM_AW] != '0)) any_leaf = 1'b1;
  end

  assign top_idx = SAW'(sp_q - SPW'(1));

  // Traversal FSM, stack push/pop and output group formation
  always_comb begin
    state_d      = state_q;
    sp_d         = sp_q;
    stack_d      = stack_q;
    node_index_d = node_index_q;
    start_prim_d = start_prim_q;
    num_prim_d   = num_prim_q;
    valid_d      = 1'b0;
    finished_d   = finished_q;
    if (restart_strobe) begin
      state_d    = S_IDLE;
      sp_d       = '0;
      finished_d = 1'b0;
    end else if (strobe) begin
      // Start, or restart from the root mid-traversal, with the current ray
      stack_d[0] = '0;
      sp_d       = SPW'(1);
      finished_d = 1'b0;
      state_d    = S_FETCH;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (sp_q == '0) begin
            state_d    = S_DONE;
            finished_d = 1'b1;
          end else begin
            node_index_d = stack_q[top_idx];
            sp_d         = sp_q - SPW'(1);
            state_d      = S_TEST;
          end
        end
        S_TEST: begin
          if (slab_hit) begin
            // Right first so the left child sits on top; a full stack drops the push
            for (int k = 1; k >= 0; k--) begin
              if (!node_isleaf[k] && (sp_d < SPW'(STACK_DEPTH))) begin
                stack_d[SAW'(sp_d)] = node_child[k*NODE_IW +: NODE_IW];
                sp_d = sp_d + SPW'(1);
              end
            end
            if (any_leaf) begin
              valid_d = 1'b1;
              for (int k = 0; k < 2; k++) begin
                start_prim_d[k*PRIM_IW +: PRIM_IW] =
                  node_isleaf[k] ? leaf_start[k*PRIM_IW +: PRIM_IW] : '0;
                num_prim_d[k*PRIM_AW +: PRIM_AW] =
                  node_isleaf[k] ? leaf_num[k*PRIM_AW +: PRIM_AW] : '0;
              end
            end
          end
          if (sp_d == '0) begin
            state_d    = S_DONE;
            finished_d = 1'b1;
          end else begin
            state_d = S_FETCH;
          end
        end
        default: ;
      endcase
    end
  end

  // State registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      sp_q         <= '0;
      for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
      node_index_q <= '0;
      start_prim_q <= '0;
      num_prim_q   <= '0;
      valid_q      <= 1'b0;
      finished_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      sp_q         <= sp_d;
      stack_q      <= stack_d;
      node_index_q <= node_index_d;
      start_prim_q <= start_prim_d;
      num_prim_q   <= num_prim_d;
      valid_q      <= valid_d;
      finished_q   <= finished_d;
    end
  end

  assign node_index = node_index_q;
  assign start_prim = start_prim_q;
  assign num_prim   = num_prim_q;
  assign valid      = valid_q;
  assign finished   = finished_q;
endmodule

// File: tb/tb_bvh_traversal_unit.sv
// Bench for bvh_traversal_unit: small node memory model, expected leaf
// groups queued by the stimulus and checked by an independent monitor.
module tb_bvh_traversal_unit;
  localparam logic [31:0] F_ZERO = 32'h0000_0000;
  localparam logic [31:0] F_ONE  = 32'h0001_0000;
  localparam logic [31:0] F_M1   = 32'hFFFF_0000;
  localparam logic [31:0] F_M5   = 32'hFFFB_0000;
  localparam logic [31:0] F_5    = 32'h0005_0000;
  localparam logic [31:0] F_10   = 32'h000A_0000;
  localparam logic [31:0] F_BIG  = 32'h0100_0000;

  logic        clk = 1'b0;
  logic        resetn, strobe, restart_strobe;
  logic [95:0] offset, ray_orig, ray_invdir;
  logic [31:0] ray_mint, ray_maxt;
  logic [7:0]  node_index;
  logic [95:0] node_min, node_max;
  logic [15:0] node_child;
  logic [1:0]  node_isleaf;
  logic [15:0] leaf_start;
  logic [7:0]  leaf_num;
  logic [15:0] start_prim;
  logic [7:0]  num_prim;
  logic        valid, finished;

  logic [95:0] m_min [256];
  logic [95:0] m_max [256];
  logic [15:0] m_child [256];
  logic [1:0]  m_leaf [256];
  logic [15:0] m_ls [256];
  logic [7:0]  m_ln [256];

  logic [23:0] exp_q [$];
  logic [7:0]  idx_log [$];
  int          errors = 0;
  int          checks = 0;

  logic [95:0] add_a, add_b, add_y, mul_v, mul_y;
  logic [31:0] mul_s;

  always #5 clk = ~clk;

  assign node_min    = m_min[node_index];
  assign node_max    = m_max[node_index];
  assign node_child  = m_child[node_index];
  assign node_isleaf = m_leaf[node_index];
  assign leaf_start  = m_ls[node_index];
  assign leaf_num    = m_ln[node_index];

  bvh_traversal_unit dut (
    .clk(clk), .resetn(resetn), .strobe(strobe), .restart_strobe(restart_strobe),
    .offset(offset), .ray_orig(ray_orig), .ray_invdir(ray_invdir),
    .ray_mint(ray_mint), .ray_maxt(ray_maxt), .node_index(node_index),
    .node_min(node_min), .node_max(node_max), .node_child(node_child),
    .node_isleaf(node_isleaf), .leaf_start(leaf_start), .leaf_num(leaf_num),
    .start_prim(start_prim), .num_prim(num_prim), .valid(valid), .finished(finished)
  );

  fixed3_add #(.FW(32)) u_add (.a(add_a), .b(add_b), .y(add_y));
  fixed3_mul #(.FW(32)) u_mul (.s(mul_s), .v(mul_v), .y(mul_y));

  function automatic logic [95:0] v3(input logic [31:0] x, input logic [31:0] y,
                                     input logic [31:0] z);
    return {z, y, x};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every valid pulse must match the oldest queued group
  always @(negedge clk) begin
    if (resetn && valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: got start=%h num=%h expected no group", start_prim, num_prim);
      end else begin
        logic [23:0] e;
        e = exp_q.pop_front();
        if ({start_prim, num_prim} !== e) begin
          errors++;
          $display("FAIL group: got %h expected %h", {start_prim, num_prim}, e);
        end
      end
    end
    if (resetn && dut.state_q == 2'd2) idx_log.push_back(node_index);
  end

  task automatic pulse_strobe();
    strobe = 1'b1;
    @(posedge clk); #1;
    strobe = 1'b0;
  endtask

  // Cycles after the strobe-sampling edge until finished rises
  task automatic wait_fin(input string name, input int exp_n);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!finished && n < 100);
    chk(name, 128'(n), 128'(exp_n));
  endtask

  task automatic drain(input string name);
    @(negedge clk); #1;
    chk(name, 128'(exp_q.size()), 128'd0);
  endtask

  task automatic scene_single();
    m_min[0] = v3(F_M1, F_M1, F_M1);
    m_max[0] = v3(F_ONE, F_ONE, F_ONE);
    m_child[0] = 16'h0000;
    m_leaf[0] = 2'b11;
    m_ls[0] = {8'd3, 8'd0};
    m_ln[0] = {4'd2, 4'd3};
  endtask

  task automatic scene_depth2();
    for (int i = 0; i < 3; i++) begin
      m_min[i] = v3(F_M1, F_M1, F_M1);
      m_max[i] = v3(F_ONE, F_ONE, F_ONE);
      m_child[i] = 16'h0000;
    end
    m_child[0] = {8'd2, 8'd1};
    m_leaf[0] = 2'b00; m_ls[0] = 16'h0; m_ln[0] = 8'h0;
    m_leaf[1] = 2'b11; m_ls[1] = {8'd11, 8'd10}; m_ln[1] = {4'd2, 4'd1};
    m_leaf[2] = 2'b11; m_ls[2] = {8'd23, 8'd20}; m_ln[2] = {4'd4, 4'd3};
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      m_min[i] = '0; m_max[i] = '0; m_child[i] = '0;
      m_leaf[i] = '0; m_ls[i] = '0; m_ln[i] = '0;
    end
    resetn = 1'b0; strobe = 1'b0; restart_strobe = 1'b0;
    offset = '0;
    ray_orig = v3(F_ZERO, F_ZERO, F_M5);
    ray_invdir = v3(F_BIG, F_BIG, F_ONE);
    ray_mint = F_ZERO;
    ray_maxt = F_M1;
    add_a = '0; add_b = '0; mul_s = '0; mul_v = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 128'(valid), 128'd0);
    chk("rst_finished", 128'(finished), 128'd0);
    chk("rst_start", 128'(start_prim), 128'd0);
    chk("rst_num", 128'(num_prim), 128'd0);
    chk("rst_index", 128'(node_index), 128'd0);
    chk("rst_state", 128'(dut.state_q), 128'd0);
    resetn = 1'b1;

    // Arithmetic helpers
    mul_s = 32'h0002_0000;
    mul_v = v3(32'h0001_8000, 32'hFFFF_8000, 32'h0000_4000);
    add_a = v3(F_ONE, 32'h0002_0000, 32'h0003_0000);
    add_b = v3(F_M1, 32'h0000_8000, F_ZERO);
    #1;
    chk("mul3", 128'(mul_y), 128'(v3(32'h0003_0000, F_M1, 32'h0000_8000)));
    chk("add3", 128'(add_y), 128'(v3(F_ZERO, 32'h0002_8000, 32'h0003_0000)));
    add_a = v3(32'h7FFF_0000, F_ZERO, F_ZERO);
    add_b = v3(F_ONE, F_ZERO, F_ZERO);
    #1;
    chk("add_wrap", 128'(add_y[31:0]), 128'h8000_0000);
    @(posedge clk); #1;

    // Single node hit
    scene_single();
    exp_q.push_back({8'd3, 8'd0, 4'd2, 4'd3});
    pulse_strobe();
    wait_fin("single_latency", 2);
    chk("single_state_done", 128'(dut.state_q), 128'd3);
    drain("single_drain");

    // Miss, ray passes beside the box
    ray_orig = v3(F_5, F_5, F_M5);
    pulse_strobe();
    wait_fin("miss_latency", 2);
    drain("miss_drain");

    // Bounded maxt: entry at t=4, so maxt=3 misses and maxt=4 just hits
    ray_orig = v3(F_ZERO, F_ZERO, F_M5);
    ray_maxt = 32'h0003_0000;
    pulse_strobe();
    wait_fin("maxt3_latency", 2);
    drain("maxt3_drain");
    ray_maxt = 32'h0004_0000;
    exp_q.push_back({8'd3, 8'd0, 4'd2, 4'd3});
    pulse_strobe();
    wait_fin("maxt4_latency", 2);
    drain("maxt4_drain");
    ray_maxt = F_M1;

    // Offset moves the box onto the ray; without it the ray misses
    offset = v3(F_10, F_ZERO, F_ZERO);
    ray_orig = v3(F_10, F_ZERO, F_M5);
    exp_q.push_back({8'd3, 8'd0, 4'd2, 4'd3});
    pulse_strobe();
    wait_fin("offset_latency", 2);
    drain("offset_drain");
    offset = '0;
    pulse_strobe();
    wait_fin("nooffset_latency", 2);
    drain("nooffset_drain");

    // Depth-2 tree: left subtree before right
    ray_orig = v3(F_ZERO, F_ZERO, F_M5);
    scene_depth2();
    idx_log.delete();
    exp_q.push_back({8'd11, 8'd10, 4'd2, 4'd1});
    exp_q.push_back({8'd23, 8'd20, 4'd4, 4'd3});
    pulse_strobe();
    wait_fin("depth2_latency", 6);
    drain("depth2_drain");
    chk("depth2_nodes", 128'(idx_log.size()), 128'd3);
    if (idx_log.size() == 3) begin
      chk("depth2_idx0", 128'(idx_log[0]), 128'd0);
      chk("depth2_idx1", 128'(idx_log[1]), 128'd1);
      chk("depth2_idx2", 128'(idx_log[2]), 128'd2);
    end

    // restart_strobe after finished
    restart_strobe = 1'b1;
    @(posedge clk); #1;
    restart_strobe = 1'b0;
    chk("restart_finished", 128'(finished), 128'd0);
    chk("restart_state", 128'(dut.state_q), 128'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("restart_stays_idle", 128'(dut.state_q), 128'd0);

    // strobe while testing node 1 restarts from root with no group for node 1
    exp_q.push_back({8'd11, 8'd10, 4'd2, 4'd1});
    exp_q.push_back({8'd23, 8'd20, 4'd4, 4'd3});
    pulse_strobe();
    repeat (3) @(posedge clk);
    #1;
    chk("abort_at_node1", 128'(node_index), 128'd1);
    chk("abort_in_test", 128'(dut.state_q), 128'd2);
    pulse_strobe();
    wait_fin("abort_latency", 6);
    drain("abort_drain");

    // Reset while in TEST of a hitting single node: nothing may come out
    scene_single();
    pulse_strobe();
    @(posedge clk); #1;
    chk("pre_reset_test", 128'(dut.state_q), 128'd2);
    resetn = 1'b0;
    #1;
    chk("midrst_valid", 128'(valid), 128'd0);
    chk("midrst_finished", 128'(finished), 128'd0);
    chk("midrst_start", 128'(start_prim), 128'd0);
    chk("midrst_num", 128'(num_prim), 128'd0);
    chk("midrst_state", 128'(dut.state_q), 128'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("postrst_finished", 128'(finished), 128'd0);
    chk("postrst_state", 128'(dut.state_q), 128'd0);
    drain("postrst_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bvh_traversal_unit.md
Name: bvh_traversal_unit

Overview:
- Traverses a binary BVH stored in external node memory for one ray.
- Reports every leaf primitive range whose ancestor boxes are hit by the ray. Each range goes to the downstream primitive FIFO for closest-hit testing.
- Sits in the surface stage between the ray input latch and the primitive-group FIFO.
- Contains combinational helpers fixed3_add (vector+vector) and fixed3_mul (scalar×vector), also used by the hit-position path.

Parameters:
- FW, 32: fixed-point word width, signed Q16.16.
- NODE_IW, 8: node index width.
- PRIM_IW, 8: primitive index width.
- PRIM_AW, 4: primitives-per-leaf count width.
- STACK_DEPTH, 16: traversal stack entries.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- strobe  in  1  start traversal of current ray; root index 0.
- restart_strobe  in  1  abort or finish; return to idle and clear finished.
- offset  in  3*FW  scene position offset added to every node box.
- ray_orig  in  3*FW  ray origin x,y,z.
- ray_invdir  in  3*FW  per-axis reciprocal direction.
- ray_mint  in  FW  minimum t.
- ray_maxt  in  FW  maximum t; negative means unbounded.
- node_index  out  NODE_IW  node memory address.
- node_min, node_max  in  3*FW each  node box, valid the cycle after node_index.
- node_child  in  2*NODE_IW  child indices [0]=left, [1]=right.
- node_isleaf  in  2  per-child leaf flag.
- leaf_start  in  2*PRIM_IW  per-child leaf start primitive.
- leaf_num  in  2*PRIM_AW  per-child leaf primitive count.
- start_prim  out  2*PRIM_IW  emitted range start per child.
- num_prim  out  2*PRIM_AW  emitted count per child; 0 = no range.
- valid  out  1  one-cycle pulse; start_prim/num_prim hold a new group.
- finished  out  1  traversal complete; held high.

Behaviour:
- Reset (resetn=0) drives all outputs and the stack pointer to 0 and puts the FSM in IDLE.
- FSM states: IDLE, FETCH, TEST, DONE.
- IDLE: on strobe, stack := {0}, finished := 0, go to FETCH.
- FETCH: pop the top entry, drive it on node_index (registered), go to TEST.
- TEST: node data is valid this cycle. Run the slab test:
  - lo = node_min+offset, hi = node_max+offset, using fixed3_add.
  - t_a = (lo−orig)*invdir and t_b = (hi−orig)*invdir, per axis.
  - tnear = max over axes of min(t_a,t_b), and ray_mint.
  - tfar = min over axes of max(t_a,t_b), and ray_maxt if ray_maxt ≥ 0.
  - Hit iff tnear ≤ tfar and tfar ≥ 0.
- TEST on hit, for each child k:
  - If node_isleaf[k]: next cycle start_prim[k] = leaf_start[k], num_prim[k] = leaf_num[k].
  - Otherwise num_prim[k] = 0 and the child is pushed. Push right before left, so left is processed first.
  - valid pulses next cycle if any leaf has leaf_num > 0.
- TEST on miss: nothing is emitted or pushed.
- After TEST: stack non-empty → FETCH; empty → DONE. Each node costs 2 cycles.
- DONE: finished = 1, registered the same cycle as the last possible valid, and held. Stays in DONE until restart_strobe or strobe.
- restart_strobe in any state → IDLE, finished := 0, stack cleared. Takes priority over strobe.
- strobe while FETCH/TEST → restart from root with the current ray. No valid pulse for the aborted node.
- Stack full: a push is dropped and traversal continues. This is a silent loss of subtree and is acceptable.
- valid is 0 whenever not in the cycle after a productive TEST. start_prim/num_prim hold their last value otherwise.
- Arithmetic:
  - Add/sub wraps at FW bits.
  - Multiply takes the 2*FW signed product bits [FW+15:16], truncated, no saturation.
  - fixed3_mul multiplies each of 3 components by one scalar.
  - Comparisons are signed.
- Ray and offset inputs are sampled combinationally during TEST. They must be held stable from strobe to finished.

Test Plan:
- Reset mid-traversal (resetn low in TEST) → all outputs 0, state IDLE, no valid after release until a new strobe.
- Single-node tree:
  - Setup: root box [−1,1]^3, both children leaves (start 0,num 3; start 3,num 2), ray orig (0,0,−5), invdir (large,large,1), maxt −1.
  - Response: one valid with start_prim={0,3}, num_prim={3,2}, then finished=1 two cycles after strobe+2.
- Miss:
  - Setup: same tree, ray orig (5,5,−5) dir +z.
  - Response: no valid, finished=1 after one TEST.
- Offset:
  - Setup: root box [−1,1]^3, offset (10,0,0), ray orig (10,0,−5).
  - Response: hit and the group emitted. The same ray with offset 0 → miss.
- Depth-2 tree (root children 1,2 internal; each with two leaves):
  - Response: node_index sequence 0,1,2 and valid pulses for node 1's leaves before node 2's.
  - restart_strobe after finished → finished=0, state IDLE.
- fixed3_mul/fixed3_add:
  - 2.0 × (1.5,−0.5,0.25) = (3.0,−1.0,0.5).
  - (1,2,3)+(−1,0.5,0) = (0,2.5,3).
  - 0x7FFF0000+0x00010000 wraps negative.
